// File: rtl/mux_unstriping_n.sv
// N-lane unstriping mux: per-lane FIFOs absorb skew, and a registered output
// re-serialises the words round-robin from lane 0, with a ready/valid handshake.
// Ports:
//   clk_Nf        clock at the aggregate word rate
//   reset         asynchronous, active-high
//   data_in       lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_in      per-lane word valid
//   ready_in      per-lane FIFO not full
//   data_out      unstriped word
//   valid_out     data_out holds a word
//   ready_out     consumer accepts data_out
//   selector      lane the next output word is taken from
//   overflow_err  sticky per-lane word-dropped flag
module mux_unstriping_n #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_Nf,
    input  logic                            reset,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_LANES-1:0]            valid_in,
    output logic [NUM_LANES-1:0]            ready_in,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic [$clog2(NUM_LANES)-1:0]    selector,
    output logic [NUM_LANES-1:0]            overflow_err
);

    localparam int SW = $clog2(NUM_LANES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_LANES-1:0]  full;
    logic [NUM_LANES-1:0]  empty;
    logic [DATA_WIDTH-1:0] head [NUM_LANES];
    logic                  load;

    // Stall on an empty lane rather than skipping it, so word order holds.
    always_comb begin
        load = (!valid_out || ready_out) && !empty[selector];
    end

    assign ready_in = ~full;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]         wr_ptr;
        logic [PW-1:0]         rd_ptr;
        logic [CW-1:0]         count;
        logic                  ovf;
        logic                  push;
        logic                  pop;

        assign full[g]         = (count == CW'(FIFO_DEPTH));
        assign empty[g]        = (count == '0);
        assign head[g]         = mem[rd_ptr];
        assign overflow_err[g] = ovf;

        // Push is gated by the registered full flag only: a full FIFO
        // rejects a push even when it pops on the same edge.
        assign push = valid_in[g] && !full[g];
        assign pop  = load && (selector == SW'(g));

        always_ff @(posedge clk_Nf or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (valid_in[g] && full[g])
                    ovf <= 1'b1;
            end
        end

        always_ff @(posedge clk_Nf) begin
            if (push)
                mem[wr_ptr] <= data_in[g*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk_Nf or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            selector  <= '0;
        end else if (load) begin
            data_out  <= head[selector];
            valid_out <= 1'b1;
            selector  <= selector + SW'(1);
        end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_unstriping_n.sv
// Self-checking bench for mux_unstriping_n (4 lanes, 32-bit, depth 4).
// A queue-based reference model predicts every output cycle by cycle.
module tb_mux_unstriping_n;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int FD = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NL*DW-1:0] din;
    logic [NL-1:0]    vin;
    logic [NL-1:0]    ready_in;
    logic [DW-1:0]    data_out;
    logic             valid_out;
    logic             rout;
    logic [1:0]       selector;
    logic [NL-1:0]    overflow_err;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mq [NL][$];
    bit            m_vout;
    logic [DW-1:0] m_dout;
    int            m_sel;
    logic [NL-1:0] m_ovf;

    always #5 clk = ~clk;

    mux_unstriping_n #(
        .NUM_LANES (NL),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk_Nf      (clk),
        .reset       (reset),
        .data_in     (din),
        .valid_in    (vin),
        .ready_in    (ready_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_out   (rout),
        .selector    (selector),
        .overflow_err(overflow_err)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mq[i].delete();
        m_vout = 1'b0;
        m_dout = '0;
        m_sel  = 0;
        m_ovf  = '0;
    endtask

    task automatic check(string tag);
        logic [NL-1:0] er;
        for (int i = 0; i < NL; i++) er[i] = (mq[i].size() < FD);
        chk({tag, ".ready_in"}, 32'(ready_in), 32'(er));
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(m_vout));
        chk({tag, ".data_out"}, data_out, m_dout);
        chk({tag, ".selector"}, 32'(selector), 32'(m_sel));
        chk({tag, ".overflow"}, 32'(overflow_err), 32'(m_ovf));
    endtask

    // One clock: decide accepts/load from pre-edge state, then apply.
    task automatic tick(string tag);
        logic [NL-1:0]    acc;
        logic [NL*DW-1:0] d;
        bit               ld;
        d = din;
        if (reset) begin
            @(posedge clk);
            model_clear();
            #1 check({tag, ".rst"});
            return;
        end
        for (int i = 0; i < NL; i++)
            acc[i] = vin[i] && (mq[i].size() < FD);
        ld = (!m_vout || rout) && (mq[m_sel].size() > 0);
        @(posedge clk);
        if (ld) begin
            m_dout = mq[m_sel].pop_front();
            m_vout = 1'b1;
            m_sel  = (m_sel + 1) % NL;
        end else if (m_vout && rout) begin
            m_vout = 1'b0;
        end
        for (int i = 0; i < NL; i++) begin
            if (acc[i])
                mq[i].push_back(d[i*DW +: DW]);
            else if (vin[i])
                m_ovf[i] = 1'b1;
        end
        #1 check(tag);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NL; i++) din[i*DW +: DW] = $urandom;
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        vin   = '1;
        rout  = 1'b1;
        rand_data();
        #2;
        repeat (3) begin
            rand_data();
            tick("reset_hold");
        end

        reset = 1'b0;
        vin   = '0;
        tick("idle");

        // Aligned stream: A words then B words on all lanes.
        vin = '1;
        rand_data();
        tick("aligned_a");
        rand_data();
        tick("aligned_b");
        vin = '0;
        repeat (10) tick("aligned_drain");

        // Lane 2 arrives three cycles late.
        vin = 4'b1011;
        rand_data();
        tick("skew_a");
        vin = '0;
        tick("skew_wait");
        tick("skew_wait");
        vin = 4'b0100;
        rand_data();
        tick("skew_late");
        vin = '0;
        repeat (8) tick("skew_drain");

        // Backpressure: fill lanes without overflowing, then release.
        rout = 1'b0;
        repeat (6) begin
            for (int i = 0; i < NL; i++) vin[i] = (mq[i].size() < FD);
            rand_data();
            tick("bp_fill");
        end
        vin  = '0;
        rout = 1'b1;
        repeat (25) tick("bp_drain");

        // Overflow on lane 1 only.
        rout = 1'b0;
        vin  = 4'b0010;
        repeat (7) begin
            rand_data();
            tick("ovf_push");
        end
        vin = '0;
        repeat (2) tick("ovf_hold");
        rout = 1'b1;
        repeat (12) tick("ovf_drain");

        // Mid-stream asynchronous reset with selector at 3.
        vin = '1;
        rand_data();
        tick("mid_fill");
        rand_data();
        tick("mid_fill");
        vin = '0;
        for (int k = 0; k < 8 && m_sel != 3; k++) tick("mid_seek");
        chk("mid.sel_reached", 32'(selector), 32'd3);
        #2 reset = 1'b1;
        model_clear();
        #1 check("mid_async");
        tick("mid_rst");
        reset = 1'b0;
        vin = '1;
        rand_data();
        tick("mid_new");
        vin = '0;
        repeat (8) tick("mid_drain");

        // Randomised traffic with occasional overflow and backpressure.
        repeat (400) begin
            for (int i = 0; i < NL; i++)
                vin[i] = ($urandom_range(0, 3) != 0) &&
                         ((mq[i].size() < FD) || ($urandom_range(0, 15) == 0));
            rout = ($urandom_range(0, 3) != 0);
            rand_data();
            tick("rand");
        end
        vin  = '0;
        rout = 1'b1;
        repeat (24) tick("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_unstriping_n.md
Name: mux_unstriping_n

Overview:
Parametrised N-lane unstriping multiplexer. It re-serialises a word stream that an upstream striper distributed round-robin across NUM_LANES lanes, lane 0 first. Each lane has its own input FIFO, so lane skew is absorbed. A registered output with a ready/valid handshake provides backpressure. It sits in the receive path after the per-lane PHY logic and replaces the fixed 2-lane unstriping mux.

Parameters:
NUM_LANES, 4, lane count; power of 2, range 2..16.
DATA_WIDTH, 32, bits per word.
FIFO_DEPTH, 4, words per lane FIFO; power of 2, range 2..16.

Ports:
clk_Nf  in  1  single clock, running at the aggregate word rate.
reset  in  1  asynchronous, active-high reset.
data_in  in  NUM_LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
valid_in  in  NUM_LANES  per-lane word valid.
ready_in  out  NUM_LANES  per-lane FIFO not full.
data_out  out  DATA_WIDTH  unstriped word.
valid_out  out  1  data_out holds a word.
ready_out  in  1  consumer accepts data_out.
selector  out  log2(NUM_LANES)  lane the next output word is taken from.
overflow_err  out  NUM_LANES  sticky flag: a word was dropped on that lane.

Behaviour:
- Reset: asynchronous, active-high. All of the following clear while reset is high:
  - data_out=0, valid_out=0, selector=0, overflow_err=0.
  - All FIFO pointers and counts cleared; ready_in=all 1s.
- Reset mid-operation discards every buffered word and the output register. After reset releases, the stream restarts at lane 0.
- Lane FIFO write:
  - At each rising edge, for lane i with valid_in[i]=1 and ready_in[i]=1, push data_in lane i.
  - ready_in[i] = !full[i]. It is combinational from registered counts only and never depends on the pop in the same cycle.
  - A push to a full FIFO is rejected even if that FIFO pops in the same cycle.
- Overflow: valid_in[i]=1 while ready_in[i]=0 drops the word and sets overflow_err[i]. The flag stays set until reset.
- Output load condition: load = (!valid_out || ready_out) && !empty[selector].
- On load:
  - data_out <= head of FIFO[selector]; valid_out <= 1.
  - Pop FIFO[selector].
  - selector <= selector+1; it wraps from NUM_LANES-1 to 0.
- If valid_out && ready_out && !load: valid_out <= 0; data_out holds its last value.
- If valid_out && !ready_out: data_out, valid_out and selector hold.
- Empty lane at selector: the block stalls and never skips, so word order is preserved. Other lanes keep filling.
- Latency:
  - A word pushed at edge E is poppable no earlier than edge E+1; there is no write-to-read bypass.
  - Minimum latency is valid_in to valid_out=1 after 2 rising edges.
  - Steady-state throughput is 1 word per cycle when all lanes are non-empty and ready_out=1.
- Simultaneous push and pop on the same FIFO (not full): both occur; the count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits; full = (count==FIFO_DEPTH).

Test Plan:
- Reset check: hold reset over 3 edges with stimulus active -> valid_out=0, data_out=0, selector=0, ready_in=4'b1111, overflow_err=0.
- Aligned stream: NUM_LANES=4; apply one word per lane per cycle, A0..A3, then B0..B3; ready_out=1 -> data_out = A0,A1,A2,A3,B0,... on consecutive cycles; first valid_out 2 edges after first push.
- Skew: lane 2 words arrive 3 cycles after the other lanes -> output A0,A1, then a stall with valid_out=0 and selector=2, then A2,A3 in order. Nothing is dropped.
- Backpressure: ready_out=0 for 6 cycles while lanes push -> data_out/selector frozen; each ready_in goes 0 after 4 words (FIFO_DEPTH=4). On release, the stream resumes in order without loss.
- Overflow: push a 5th word on lane 1 while it is full -> the word is dropped, overflow_err=4'b0010 and stays set; the other lanes are unaffected.
- Mid-stream reset: assert reset while selector=3 with FIFOs half full -> all outputs cleared immediately (asynchronous). New data after release is output starting from lane 0.
